bk_subtractor_pipe: RTL and testbench

//  Pipelined N-bit Brent-Kung subtractor: computes a - b - bin with borrow-out and signed overflow.

---
 rtl/bk_pkg.sv | 46 ++++
 rtl/bk_gp_cell.sv | 14 +
 rtl/bk_subtractor_pipe.sv | 162 ++++++++++++++++
 tb/tb_bk_subtractor_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared Brent-Kung helpers: the (g,p) pair type, log2 and prefix-tree level bookkeeping.
// The adder and subtractor pipelines both build their trees from these.
package bk_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  // Ceiling log2, usable in parameter defaults.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Combine levels in the tree: log2n up-sweep levels followed by log2n-1 down-sweep levels.
  function automatic int prefix_levels(input int n);
    return (2 * clog2(n)) - 1;
  endfunction

  // Span between the high and low operand of a combine at level lvl (1-based).
  function automatic int level_dist(input int log2n, input int lvl);
    if (lvl <= log2n) begin
      return 1 << (lvl - 1);
    end
    return 1 << ((2 * log2n) - lvl - 1);
  endfunction

  // Whether bit i holds a combine cell at level lvl; otherwise it passes through.
  function automatic bit level_active(input int log2n, input int lvl, input int i);
    int d;
    d = level_dist(log2n, lvl);
    if (lvl <= log2n) begin
      return ((i + 1) % (2 * d)) == 0;
    end
    return (((i + 1) % (2 * d)) == d) && (i > d);
  endfunction

endpackage

// File: rtl/bk_gp_cell.sv
// Brent-Kung (g,p) combine: merges a higher group with the adjacent lower group.
module bk_gp_cell (
  input  logic gh_i,
  input  logic ph_i,
  input  logic gl_i,
  input  logic pl_i,
  output logic g_o,
  output logic p_o
);

  assign g_o = gh_i | (ph_i & gl_i);
  assign p_o = ph_i & pl_i;

endmodule

// File: rtl/bk_subtractor_pipe.sv
// Three-stage pipelined Brent-Kung subtractor: diff = a - b - bin, with borrow-out and signed
// overflow. Computed as a + ~b + ~bin on a shared prefix tree; valid/ready on both sides.
module bk_subtractor_pipe
  import bk_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned LOG2N = clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf
);

  localparam int Levels = prefix_levels(int'(N));

  logic         v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic         ld1, ld2, ld3, drain3;
  logic [N-1:0] p1_q, p1_d, g1_q, g1_d;
  logic         c01_q, c01_d;
  logic [N-1:0] gg2_q, gg2_d, gp2_q, gp2_d, p2_q, p2_d;
  logic         c02_q, c02_d;
  logic [N-1:0] diff_q, diff_d;
  logic         bout_q, bout_d, ovf_q, ovf_d;
  logic [N-1:0] tree_g, tree_p;
  logic [N:0]   c;

  // Handshake: each stage advances when it is empty or its successor frees up this cycle.
  always_comb begin
    drain3   = v3_q & out_ready;
    ld3      = v2_q & (~v3_q | drain3);
    ld2      = v1_q & (~v2_q | ld3);
    // Held low during reset so no beat is accepted and then discarded.
    in_ready = ~rst & (~v1_q | ld2);
    ld1      = in_valid & in_ready;
    v1_d     = ld1 | (v1_q & ~ld2);
    v2_d     = ld2 | (v2_q & ~ld3);
    v3_d     = ld3 | (v3_q & ~drain3);
  end

  // S1 next state: bitwise propagate/generate of a and ~b, carry-in is ~bin.
  always_comb begin
    p1_d  = p1_q;
    g1_d  = g1_q;
    c01_d = c01_q;
    if (ld1) begin
      p1_d  = a ^ ~b;
      g1_d  = a & ~b;
      c01_d = ~bin;
    end
  end

  // Prefix tree: one generate block per level, each reading the previous level's outputs.
  for (genvar l = 0; l < Levels; l++) begin : g_lvl
    localparam int Dist = level_dist(int'(LOG2N), l + 1);
    logic [N-1:0] g_in, p_in, g_out, p_out;

    if (l == 0) begin : g_src
      assign g_in = g1_q;
      assign p_in = p1_q;
    end else begin : g_src
      assign g_in = g_lvl[l-1].g_out;
      assign p_in = g_lvl[l-1].p_out;
    end

    for (genvar i = 0; i < N; i++) begin : g_bit
      if (level_active(int'(LOG2N), l + 1, i)) begin : g_cell
        bk_gp_cell u_cell (
          .gh_i (g_in[i]),
          .ph_i (p_in[i]),
          .gl_i (g_in[i-Dist]),
          .pl_i (p_in[i-Dist]),
          .g_o  (g_out[i]),
          .p_o  (p_out[i])
        );
      end else begin : g_pass
        assign g_out[i] = g_in[i];
        assign p_out[i] = p_in[i];
      end
    end
  end

  assign tree_g = g_lvl[Levels-1].g_out;
  assign tree_p = g_lvl[Levels-1].p_out;

  // S2 next state: group G/P over [i:0] for every bit, plus the operands S3 still needs.
  always_comb begin
    gg2_d = gg2_q;
    gp2_d = gp2_q;
    p2_d  = p2_q;
    c02_d = c02_q;
    if (ld2) begin
      gg2_d = tree_g;
      gp2_d = tree_p;
      p2_d  = p1_q;
      c02_d = c01_q;
    end
  end

  // S3 next state: fold carry-in into the group terms, then form diff and flags.
  always_comb begin
    c[0] = c02_q;
    for (int i = 0; i < int'(N); i++) begin
      c[i+1] = gg2_q[i] | (gp2_q[i] & c02_q);
    end
    diff_d = diff_q;
    bout_d = bout_q;
    ovf_d  = ovf_q;
    if (ld3) begin
      diff_d = p2_q ^ c[N-1:0];
      bout_d = ~c[N];
      ovf_d  = c[N] ^ c[N-1];
    end
  end

  // All pipeline state, synchronously cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      p1_q   <= '0;
      g1_q   <= '0;
      c01_q  <= 1'b0;
      gg2_q  <= '0;
      gp2_q  <= '0;
      p2_q   <= '0;
      c02_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      p1_q   <= p1_d;
      g1_q   <= g1_d;
      c01_q  <= c01_d;
      gg2_q  <= gg2_d;
      gp2_q  <= gp2_d;
      p2_q   <= p2_d;
      c02_q  <= c02_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = v3_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_bk_subtractor_pipe.sv
// Bench for bk_subtractor_pipe: N=4 and N=16 instances, scoreboard against an a-b-bin model.
module tb_bk_subtractor_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv4, ir4, ov4, or4, bin4, bo4, of4;
  logic [3:0]  a4, b4, d4;
  logic        iv16, ir16, ov16, or16, bin16, bo16, of16;
  logic [15:0] a16, b16, d16;

  int checks = 0;
  int passed = 0;
  int outs4  = 0;

  logic [17:0] q4[$];
  logic [17:0] q16[$];
  logic [17:0] e4, g4, e16, g16;

  bk_subtractor_pipe #(.N(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv4),
    .in_ready  (ir4),
    .a         (a4),
    .b         (b4),
    .bin       (bin4),
    .out_valid (ov4),
    .out_ready (or4),
    .diff      (d4),
    .bout      (bo4),
    .ovf       (of4)
  );

  bk_subtractor_pipe #(.N(16)) u_dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .a         (a16),
    .b         (b16),
    .bin       (bin16),
    .out_valid (ov16),
    .out_ready (or16),
    .diff      (d16),
    .bout      (bo16),
    .ovf       (of16)
  );

  // Behavioural reference: returns {ovf, bout, diff[15:0]} for a w-bit subtraction.
  function automatic logic [17:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic bin);
    int ua, ub, ud, sa, sb, sd;
    logic [15:0] d;
    logic bo, ov;
    ua = int'(a);
    ub = int'(b);
    ud = ua - ub - int'(bin);
    bo = (ud < 0);
    d  = 16'(ud & ((1 << w) - 1));
    sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
    sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
    sd = sa - sb - int'(bin);
    ov = (sd < -(1 << (w - 1))) || (sd > ((1 << (w - 1)) - 1));
    return {ov, bo, d};
  endfunction

  // Scoreboard: push on input transfer, pop and compare on output transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (iv4 && ir4) q4.push_back(model(4, {12'b0, a4}, {12'b0, b4}, bin4));
      if (iv16 && ir16) q16.push_back(model(16, a16, b16, bin16));
      if (ov4 && or4) begin
        outs4++;
        checks++;
        if (q4.size() == 0) begin
          $display("FAIL sb4_unexpected: got diff=%h bout=%b ovf=%b, no beat expected", d4, bo4, of4);
        end else begin
          e4 = q4.pop_front();
          g4 = {of4, bo4, 12'b0, d4};
          if (g4 !== e4) $display("FAIL sb4: got %h want %h", g4, e4);
          else passed++;
        end
      end
      if (ov16 && or16) begin
        checks++;
        if (q16.size() == 0) begin
          $display("FAIL sb16_unexpected: got diff=%h, no beat expected", d16);
        end else begin
          e16 = q16.pop_front();
          g16 = {of16, bo16, d16};
          if (g16 !== e16) $display("FAIL sb16: got %h want %h", g16, e16);
          else passed++;
        end
      end
    end
  end

  task automatic wait_drain();
    for (int c = 0; c < 200 && (q4.size() != 0 || q16.size() != 0); c++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    iv4 = 0; a4 = '0; b4 = '0; bin4 = 0; or4 = 1;
    iv16 = 0; a16 = '0; b16 = '0; bin16 = 0; or16 = 1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++; if (ov4 !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", ov4); else passed++;
    checks++; if (d4 !== 4'h0) $display("FAIL reset_diff: got %h want 0", d4); else passed++;
    checks++; if (bo4 !== 1'b0) $display("FAIL reset_bout: got %b want 0", bo4); else passed++;
    checks++; if (of4 !== 1'b0) $display("FAIL reset_ovf: got %b want 0", of4); else passed++;
    checks++; if (ir4 !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", ir4); else passed++;
    checks++; if (ov16 !== 1'b0) $display("FAIL reset_out_valid16: got %b want 0", ov16); else passed++;
  endtask

  task automatic test_directed();
    logic [3:0] ta[3], tb[3], td[3];
    logic       tbin[3], tbo[3], tov[3];
    ta = '{4'h3, 4'h8, 4'h0}; tb = '{4'h5, 4'h1, 4'h0}; tbin = '{1'b0, 1'b0, 1'b1};
    td = '{4'hE, 4'h7, 4'hF}; tbo = '{1'b1, 1'b0, 1'b1}; tov = '{1'b0, 1'b1, 1'b0};
    or4 = 1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1 a4 = ta[k]; b4 = tb[k]; bin4 = tbin[k]; iv4 = 1;
      @(posedge clk); #1 iv4 = 0;
      @(negedge clk);
      checks++; if (ov4 !== 1'b0) $display("FAIL lat_edge1[%0d]: got %b want 0", k, ov4); else passed++;
      @(negedge clk);
      checks++; if (ov4 !== 1'b0) $display("FAIL lat_edge2[%0d]: got %b want 0", k, ov4); else passed++;
      @(negedge clk);
      checks++; if (ov4 !== 1'b1) $display("FAIL lat_edge3[%0d]: got %b want 1", k, ov4); else passed++;
      checks++; if (d4 !== td[k]) $display("FAIL dir_diff[%0d]: got %h want %h", k, d4, td[k]); else passed++;
      checks++; if (bo4 !== tbo[k]) $display("FAIL dir_bout[%0d]: got %b want %b", k, bo4, tbo[k]); else passed++;
      checks++; if (of4 !== tov[k]) $display("FAIL dir_ovf[%0d]: got %b want %b", k, of4, tov[k]); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int first, last, highs;
    first = -1; last = -1; highs = 0;
    or4 = 1;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (k < 16) begin
        iv4 = 1; a4 = 4'(k); b4 = 4'(k * 7 + 3); bin4 = k[0];
      end else begin
        iv4 = 0;
      end
      @(negedge clk);
      if (k < 16) begin
        checks++; if (ir4 !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", k, ir4); else passed++;
      end
      if (ov4) begin
        highs++;
        if (first < 0) first = k;
        last = k;
      end
    end
    checks++; if (highs != 16) $display("FAIL b2b_count: got %0d want 16", highs); else passed++;
    checks++; if (last - first != 15) $display("FAIL b2b_contiguous: got span %0d want 15", last - first); else passed++;
  endtask

  task automatic test_stall();
    logic [3:0]  sa[5], sb[5];
    logic [17:0] m0;
    int k, cyc;
    sa = '{4'h9, 4'h2, 4'h7, 4'hC, 4'h1};
    sb = '{4'h4, 4'hB, 4'h7, 4'h3, 4'hF};
    m0 = model(4, {12'b0, sa[0]}, {12'b0, sb[0]}, 1'b1);
    k = 0;
    bin4 = 1;
    or4 = 0;
    for (cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      if (k < 5) begin iv4 = 1; a4 = sa[k]; b4 = sb[k]; end else iv4 = 0;
      @(negedge clk);
      if (cyc < 3) begin
        checks++; if (ir4 !== 1'b1) $display("FAIL stall_fill_ready[%0d]: got %b want 1", cyc, ir4); else passed++;
      end
      if (ov4) begin
        checks++;
        if ({of4, bo4, d4} !== {m0[17:16], m0[3:0]})
          $display("FAIL stall_hold[%0d]: got %h want %h", cyc, {of4, bo4, d4}, {m0[17:16], m0[3:0]});
        else passed++;
      end
      if (iv4 && ir4) k++;
    end
    checks++; if (k != 3) $display("FAIL stall_accepted: got %0d want 3", k); else passed++;
    checks++; if (ir4 !== 1'b0) $display("FAIL stall_in_ready: got %b want 0", ir4); else passed++;
    checks++; if (ov4 !== 1'b1) $display("FAIL stall_out_valid: got %b want 1", ov4); else passed++;
    cyc = 0;
    while (k < 5 && cyc < 50) begin
      @(posedge clk); #1 or4 = 1; iv4 = 1; a4 = sa[k]; b4 = sb[k];
      @(negedge clk);
      if (iv4 && ir4) k++;
      cyc++;
    end
    @(posedge clk); #1 iv4 = 0;
    checks++; if (k != 5) $display("FAIL stall_release: got %0d beats want 5", k); else passed++;
    wait_drain();
    checks++; if (q4.size() != 0) $display("FAIL stall_drain: got %0d pending want 0", q4.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    or4 = 1;
    @(posedge clk); #1 iv4 = 1; a4 = 4'h6; b4 = 4'h2; bin4 = 0;
    @(posedge clk); #1 a4 = 4'hA; b4 = 4'h3;
    @(posedge clk); #1 iv4 = 0; rst = 1; q4.delete();
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    checks++; if (ov4 !== 1'b0) $display("FAIL rst_mid_valid: got %b want 0", ov4); else passed++;
    checks++; if ({of4, bo4, d4} !== 6'h0) $display("FAIL rst_mid_data: got %h want 0", {of4, bo4, d4}); else passed++;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (ov4 !== 1'b0) $display("FAIL rst_mid_stale[%0d]: got %b want 0", c, ov4); else passed++;
    end
  endtask

  task automatic test_exhaustive4();
    int k, cyc, start;
    k = 0; cyc = 0; start = outs4;
    while (k < 512 && cyc < 5000) begin
      @(posedge clk); #1;
      or4 = 1'($urandom_range(0, 1));
      iv4 = 1;
      {bin4, a4, b4} = 9'(k);
      @(negedge clk);
      if (ir4) k++;
      cyc++;
    end
    @(posedge clk); #1 iv4 = 0; or4 = 1;
    checks++; if (k != 512) $display("FAIL exh4_sent: got %0d want 512", k); else passed++;
    wait_drain();
    checks++; if (outs4 - start != 512) $display("FAIL exh4_outs: got %0d want 512", outs4 - start); else passed++;
  endtask

  task automatic test_random16();
    int k, cyc;
    logic need;
    k = 0; cyc = 0; need = 1;
    while (k < 10000 && cyc < 40000) begin
      @(posedge clk); #1;
      or16 = ($urandom_range(0, 3) != 0);
      if (need) begin
        a16 = 16'($urandom); b16 = 16'($urandom); bin16 = 1'($urandom_range(0, 1));
        iv16 = 1; need = 0;
      end
      @(negedge clk);
      if (ir16) begin k++; need = 1; end
      cyc++;
    end
    @(posedge clk); #1 iv16 = 0; or16 = 1;
    checks++; if (k != 10000) $display("FAIL rnd16_sent: got %0d want 10000", k); else passed++;
    wait_drain();
    checks++; if (q16.size() != 0) $display("FAIL rnd16_drain: got %0d pending want 0", q16.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_exhaustive4();
    test_random16();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule
